perf_csr_port: RTL and testbench
================================

# perf_csr_port

CSR-side access port for the performance-counter bank: services 32-bit CSR read/write requests from the core's CSR stage against `N_CNT` 64-bit counters, each exposed as low/high 32-bit halves. Reads of the low half snapshot the matching high half, so a low-then-high read pair returns a coherent 64-bit value even across a carry. Writes drive the counters' load interface. Sits between the CSR decode/execute stage and the counter instances.

## Interface
- `XLEN`, 32, CSR data width
- `N_CNT`, 4, number of counters; index 0..N_CNT-1 (max 32)
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `clk_en`  in  1  global clock enable; all state advances only when 1
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready && clk_en`
- `req_addr`  in  12  CSR address
- `req_write`  in  1  1 = write, 0 = read
- `req_wdata`  in  XLEN  write data
- `req_mmode`  in  1  1 = machine mode, 0 = user mode
- `user_en`  in  N_CNT  per-counter user read enable (mcounteren)
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready && clk_en`
- `rsp_rdata`  out  XLEN  read data (0 on writes and errors)
- `rsp_err`  out  1  illegal access
- `cnt_lo`  in  N_CNT x XLEN  live counter low halves
- `cnt_hi`  in  N_CNT x XLEN  live counter high halves
- `ld_en`  out  N_CNT  one-cycle load strobe per counter
- `ld_hi`  out  1  1 = load high half, 0 = low half
- `ld_data`  out  XLEN  load value

## Operation
- Address map (idx = addr[4:0]): 0xB00+idx M low RW; 0xB80+idx M high RW; 0xC00+idx U/M low RO; 0xC80+idx U/M high RO.
- Error (`rsp_err`=1, rdata 0, no load, snapshot untouched) when: address outside map; idx >= N_CNT; write to 0xCxx; 0xBxx access with `req_mmode`=0; 0xCxx access with `req_mmode`=0 and `user_en[idx]`=0.
- FSM states IDLE, EXEC, RESP. IDLE: `req_ready`=1; on accept latch addr/write/wdata/mode, go EXEC. EXEC: decode, sample counters, issue load, register response, go RESP. RESP: `rsp_valid`=1, hold data stable until consumed, then IDLE.
- Snapshot: one register `snap_data`[XLEN], `snap_idx`, `snap_vld`. Legal low-half read of idx: capture `cnt_hi[idx]` the same cycle `cnt_lo[idx]` is sampled, `snap_vld`=1.
- Legal high-half read: if `snap_vld` and `snap_idx`==idx return `snap_data`, clear `snap_vld`; otherwise return live `cnt_hi[idx]`, snapshot unchanged.
- Legal write: `ld_en[idx]`=1 for exactly one clk_en cycle in EXEC, `ld_hi` = addr[7], `ld_data` = wdata. Any write with `snap_idx`==idx clears `snap_vld`.
- Load has priority over increment inside the counter (counter-side contract).

## Timing
- Reset: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `ld_en`=0, `ld_hi`=0, `ld_data`=0, `snap_vld`=0.
- Accept at clk_en edge T -> EXEC at T+1 -> `rsp_valid` at T+2 (two clk_en cycles). Loaded value visible on `cnt_lo/hi` at T+3.
- `req_ready`=0 in EXEC and RESP; no pipelining, one outstanding request.
- Response consumed at edge C -> `req_ready`=1 from C+1; back-to-back throughput one request per 3 clk_en cycles minimum.
- `clk_en`=0: all registers hold, including `ld_en` (strobe stretched, not duplicated in counter as counter also gates on clk_en).
- `rst_n` asserted mid-transaction: abort, return to reset values immediately; no partial load.

## Structure
- Shared package `core_config_pkg`: `XLEN`, CSR base constants (`CSR_MCYCLE`=0xB00, `CSR_MCYCLEH`=0xB80, `CSR_CYCLE`=0xC00, `CSR_CYCLEH`=0xC80), FSM state enum `perf_csr_state_t`.
- Sub-module `perf_csr_decode` (combinational): addr/mode/user_en/write -> idx, hi, legal, err.

## Test plan
- M read 0xB00 with cnt0 = 0x0000_0001_FFFF_FFFF, counter carries before high read -> rdata 0xFFFF_FFFF, then read 0xB80 -> 0x0000_0001 (snapshot), snap_vld cleared.
- Read 0xB81 without prior low read, cnt_hi[1]=0x1234 -> 0x1234 live; snapshot of idx0 still valid afterward.
- M write 0xB02 data 0xDEAD_BEEF -> ld_en=4'b0100, ld_hi=0, one clk_en cycle; rsp_valid at T+2, rdata 0, err 0.
- User read 0xC03 with user_en[3]=0 -> err=1, rdata 0; user write 0xC00 -> err=1, no ld_en; idx 5 with N_CNT=4 -> err=1.
- rsp_ready held 0 for 5 cycles, then clk_en toggled -> rsp_rdata stable, req_ready 0 throughout, single response.
- rst_n asserted during EXEC of a write -> ld_en stays 0, outputs at reset values, req_ready=1 after release.

Source files
------------

// File: rtl/core_config_pkg.sv
// core_config_pkg: shared core constants, CSR base addresses and perf CSR FSM states
package core_config_pkg;
  localparam int XLEN = 32;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
  localparam logic [11:0] CSR_CYCLE   = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH  = 12'hC80;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } perf_csr_state_t;
endpackage

// File: rtl/perf_csr_decode.sv
// perf_csr_decode: classifies a CSR access to the counter bank as legal or illegal
module perf_csr_decode
  import core_config_pkg::*;
#(
  parameter int N_CNT = 4
) (
  input  logic [11:0]      addr,
  input  logic             mmode,
  input  logic             write,
  input  logic [N_CNT-1:0] user_en,
  output logic [4:0]       idx,
  output logic             hi,
  output logic             legal,
  output logic             err
);
  logic m_space;
  logic u_space;
  logic idx_ok;
  logic ue;
  logic [31:0] ue_ext;
  // each window spans 32 addresses, so addr[11:5] identifies the window
  always_comb begin
    idx     = addr[4:0];
    hi      = addr[7];
    m_space = (addr[11:5] == CSR_MCYCLE[11:5]) || (addr[11:5] == CSR_MCYCLEH[11:5]);
    u_space = (addr[11:5] == CSR_CYCLE[11:5]) || (addr[11:5] == CSR_CYCLEH[11:5]);
    idx_ok  = 32'(idx) < N_CNT;
    ue_ext  = 32'(user_en);
    ue      = ue_ext[idx];
    err     = !(m_space || u_space) || !idx_ok || (u_space && write) ||
              (m_space && !mmode) || (u_space && !mmode && !ue);
    legal   = !err;
  end
endmodule

// File: rtl/perf_csr_port.sv
// perf_csr_port: CSR access port for the 64-bit performance counter bank
module perf_csr_port
  import core_config_pkg::*;
#(
  parameter int N_CNT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [11:0]                req_addr,
  input  logic                       req_write,
  input  logic [XLEN-1:0]            req_wdata,
  input  logic                       req_mmode,
  input  logic [N_CNT-1:0]           user_en,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [XLEN-1:0]            rsp_rdata,
  output logic                       rsp_err,
  input  logic [N_CNT-1:0][XLEN-1:0] cnt_lo,
  input  logic [N_CNT-1:0][XLEN-1:0] cnt_hi,
  output logic [N_CNT-1:0]           ld_en,
  output logic                       ld_hi,
  output logic [XLEN-1:0]            ld_data
);
  localparam int IW = N_CNT > 1 ? $clog2(N_CNT) : 1;
  perf_csr_state_t state, state_d;
  logic [11:0]      a_addr;
  logic             a_write;
  logic [XLEN-1:0]  a_wdata;
  logic             a_mmode;
  logic [4:0]       idx;
  logic [IW-1:0]    ic;
  logic             hi;
  logic             legal;
  logic             err;
  logic [XLEN-1:0]  rd_data;
  logic [N_CNT-1:0] one_hot;
  logic [XLEN-1:0]  snap_data;
  logic [4:0]       snap_idx;
  logic             snap_vld;
  logic             snap_hit;

  perf_csr_decode #(.N_CNT(N_CNT)) u_decode (
    .addr    (a_addr),
    .mmode   (a_mmode),
    .write   (a_write),
    .user_en (user_en),
    .idx     (idx),
    .hi      (hi),
    .legal   (legal),
    .err     (err)
  );

  assign ic       = idx[IW-1:0];
  assign one_hot  = N_CNT'(1) << idx;
  assign snap_hit = snap_vld && (snap_idx == idx);
  assign rd_data  = (!legal || a_write) ? '0 : !hi ? cnt_lo[ic] : snap_hit ? snap_data : cnt_hi[ic];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_d;
  end

  // next state and handshake outputs; one request in flight at a time
  always_comb begin
    state_d   = state;
    req_ready = state == ST_IDLE;
    rsp_valid = state == ST_RESP;
    if (clk_en)
      state_d = (state == ST_IDLE && req_valid) ? ST_EXEC :
                (state == ST_EXEC) ? ST_RESP :
                (state == ST_RESP && rsp_ready) ? ST_IDLE : state;
  end

  // request latch, response register and load strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_addr    <= '0;
      a_write   <= 1'b0;
      a_wdata   <= '0;
      a_mmode   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ld_en     <= '0;
      ld_hi     <= 1'b0;
      ld_data   <= '0;
    end else if (clk_en) begin
      if (state == ST_IDLE && req_valid) begin
        a_addr  <= req_addr;
        a_write <= req_write;
        a_wdata <= req_wdata;
        a_mmode <= req_mmode;
      end
      ld_en <= (state == ST_EXEC && legal && a_write) ? one_hot : '0;
      if (state == ST_EXEC) begin
        rsp_rdata <= rd_data;
        rsp_err   <= err;
        if (legal && a_write) begin
          ld_hi   <= hi;
          ld_data <= a_wdata;
        end
      end
    end
  end

  // low-half reads capture the high half; a matching high read or write consumes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_data <= '0;
      snap_idx  <= '0;
      snap_vld  <= 1'b0;
    end else if (clk_en && state == ST_EXEC && legal) begin
      if (!a_write && !hi) begin
        snap_data <= cnt_hi[ic];
        snap_idx  <= idx;
        snap_vld  <= 1'b1;
      end else if (snap_idx == idx) begin
        snap_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_perf_csr_port.sv
// tb_perf_csr_port: directed scoreboard bench for the perf counter CSR port
module tb_perf_csr_port;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_en = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [11:0]      req_addr = '0;
  logic             req_write = 1'b0;
  logic [31:0]      req_wdata = '0;
  logic             req_mmode = 1'b0;
  logic [3:0]       user_en = 4'b0111;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [3:0][31:0] cnt_lo = '0;
  logic [3:0][31:0] cnt_hi = '0;
  logic [3:0]       ld_en;
  logic             ld_hi;
  logic [31:0]      ld_data;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] held;

  perf_csr_port #(.N_CNT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_mmode (req_mmode),
    .user_en   (user_en),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .cnt_lo    (cnt_lo),
    .cnt_hi    (cnt_hi),
    .ld_en     (ld_en),
    .ld_hi     (ld_hi),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [11:0] a, input logic w, input logic [31:0] d, input logic m);
    int n = 0;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_mmode = m;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, rsp_err, e.err);
    end
  endtask

  task automatic txn(input string tag, input logic [11:0] a, input logic w, input logic [31:0] d,
                     input logic m, input logic [31:0] er, input logic ee, input logic [3:0] el);
    sb.push_back('{er, ee});
    drive(a, w, d, m);
    chk({tag, "_exec_ready"}, req_ready, 0);
    chk({tag, "_exec_valid"}, rsp_valid, 0);
    step();
    chk({tag, "_resp_valid"}, rsp_valid, 1);
    chk({tag, "_ld_en"}, ld_en, el);
    if (el != 0) begin
      chk({tag, "_ld_hi"}, ld_hi, a[7]);
      chk({tag, "_ld_data"}, ld_data, d);
    end
    rsp_ready = 1'b1;
    pop_check(tag);
    step();
    rsp_ready = 1'b0;
    chk({tag, "_ld_clr"}, ld_en, 0);
    chk({tag, "_idle_valid"}, rsp_valid, 0);
    chk({tag, "_idle_ready"}, req_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ld_en", ld_en, 0);
    chk("rst_ld_hi", ld_hi, 0);
    chk("rst_ld_data", ld_data, 0);
    rst_n = 1'b1;
    step();
    cnt_lo[0] = 32'hFFFF_FFFF;
    cnt_hi[0] = 32'h1;
    txn("lo_carry", 12'hB00, 0, 0, 1, 32'hFFFF_FFFF, 0, 4'b0000);
    cnt_lo[0] = 32'h0;
    cnt_hi[0] = 32'h2;
    txn("hi_snap", 12'hB80, 0, 0, 1, 32'h1, 0, 4'b0000);
    txn("hi_live", 12'hB80, 0, 0, 1, 32'h2, 0, 4'b0000);
    cnt_lo[0] = 32'h7;
    cnt_hi[0] = 32'h5;
    txn("lo0", 12'hB00, 0, 0, 1, 32'h7, 0, 4'b0000);
    cnt_hi[0] = 32'h6;
    cnt_lo[1] = 32'h11;
    cnt_hi[1] = 32'h1234;
    txn("hi1_live", 12'hB81, 0, 0, 1, 32'h1234, 0, 4'b0000);
    txn("hi0_keep", 12'hB80, 0, 0, 1, 32'h5, 0, 4'b0000);
    txn("hi0_after", 12'hB80, 0, 0, 1, 32'h6, 0, 4'b0000);
    txn("wr_b02", 12'hB02, 1, 32'hDEAD_BEEF, 1, 32'h0, 0, 4'b0100);
    txn("wr_b83", 12'hB83, 1, 32'h55, 1, 32'h0, 0, 4'b1000);
    txn("lo1", 12'hB01, 0, 0, 1, 32'h11, 0, 4'b0000);
    cnt_hi[1] = 32'h4321;
    txn("wr_b81", 12'hB81, 1, 32'h9, 1, 32'h0, 0, 4'b0010);
    txn("hi1_inval", 12'hB81, 0, 0, 1, 32'h4321, 0, 4'b0000);
    cnt_hi[3] = 32'hABCD;
    txn("u_c03_dis", 12'hC03, 0, 0, 0, 32'h0, 1, 4'b0000);
    txn("u_c01_ok", 12'hC01, 0, 0, 0, 32'h11, 0, 4'b0000);
    txn("u_wr_c00", 12'hC00, 1, 32'h1, 0, 32'h0, 1, 4'b0000);
    txn("m_wr_c00", 12'hC00, 1, 32'h1, 1, 32'h0, 1, 4'b0000);
    txn("idx5", 12'hB05, 0, 0, 1, 32'h0, 1, 4'b0000);
    txn("u_b00", 12'hB00, 0, 0, 0, 32'h0, 1, 4'b0000);
    txn("out_map", 12'h300, 0, 0, 1, 32'h0, 1, 4'b0000);
    txn("m_c83", 12'hC83, 0, 0, 1, 32'hABCD, 0, 4'b0000);
    txn("lo0_b", 12'hB00, 0, 0, 1, 32'h7, 0, 4'b0000);
    cnt_hi[0] = 32'h8;
    txn("err_wr_keep", 12'hB80, 1, 32'h3, 0, 32'h0, 1, 4'b0000);
    txn("hi0_snap_b", 12'hB80, 0, 0, 1, 32'h6, 0, 4'b0000);
    cnt_lo[2] = 32'h22;
    sb.push_back('{32'h22, 1'b0});
    drive(12'hB02, 0, 0, 1);
    step();
    cnt_lo[2] = 32'h99;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_ready", req_ready, 0);
      chk("stall_rdata", rsp_rdata, 32'h22);
    end
    rsp_ready = 1'b1;
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ce0_valid", rsp_valid, 1);
      chk("ce0_rdata", rsp_rdata, 32'h22);
    end
    clk_en = 1'b1;
    pop_check("stall");
    step();
    rsp_ready = 1'b0;
    chk("stall_done", rsp_valid, 0);
    step();
    chk("stall_single", rsp_valid, 0);
    drive(12'hB00, 1, 32'h77, 1);
    step();
    clk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ld_stretch", ld_en, 4'b0001);
    end
    clk_en = 1'b1;
    step();
    chk("ld_stretch_end", ld_en, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("ld_back_idle", req_ready, 1);
    cnt_hi[0] = 32'h8;
    txn("lo0_c", 12'hB00, 0, 0, 1, 32'h7, 0, 4'b0000);
    cnt_hi[0] = 32'h9;
    drive(12'hB01, 1, 32'hF, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ld_en", ld_en, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_err", rsp_err, 0);
    step();
    step();
    chk("arst_ld_hold", ld_en, 0);
    rst_n = 1'b1;
    step();
    chk("rel_req_ready", req_ready, 1);
    chk("rel_ld_en", ld_en, 0);
    txn("snap_rst", 12'hB80, 0, 0, 1, 32'h9, 0, 4'b0000);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
